rst_seq: RTL

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 28 ++
 rtl/reset_sync.sv | 24 ++
 rtl/rst_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared state encoding, reset-cause codes and sizing helper for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_LOCK   = 3'd1,
    S_PERIPH = 3'd2,
    S_MEM    = 3'd3,
    S_CPU    = 3'd4,
    S_RUN    = 3'd5,
    S_SWRST  = 3'd6
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
  localparam logic [1:0] CAUSE_PLL = 2'b11;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-release reset synchronizer of STAGES flops.
module reset_sync #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_in_n,
  output logic rst_sync_n
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) sync_q <= '0;
    else           sync_q <= sync_d;
  end

  assign rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Power-on / software / watchdog / PLL-loss reset sequencer releasing the
// peripheral, memory and CPU resets in order, each from a single flop.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int PERIPH_DLY  = 16,
  parameter int MEM_DLY     = 64,
  parameter int CPU_DLY     = 16,
  parameter int SW_HOLD     = 32
) (
  input  logic       clk,
  input  logic       rst_in_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  input  logic       wdt_expire,
  output logic       rst_periph_n,
  output logic       rst_mem_n,
  output logic       rst_cpu_n,
  output logic [1:0] rst_cause,
  output logic       seq_done
);

  localparam int CNT_W = $clog2(max4(PERIPH_DLY, MEM_DLY, CPU_DLY, SW_HOLD)) + 1;
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DLY - 1);
  localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_DLY - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DLY - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic             rst_sync_n;
  logic [1:0]       pll_q, pll_d;
  logic             pll_sync;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             periph_q, periph_d;
  logic             mem_q, mem_d;
  logic             cpu_q, cpu_d;
  logic             done_q, done_d;

  reset_sync #(
    .STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk       (clk),
    .rst_in_n  (rst_in_n),
    .rst_sync_n(rst_sync_n)
  );

  always_comb begin
    pll_d = {pll_q[0], pll_locked};
  end

  assign pll_sync = pll_q[1];

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_HOLD:   if (rst_sync_n) state_d = S_LOCK;
      S_LOCK:   if (pll_sync) state_d = S_PERIPH;
      S_PERIPH: begin
        if (!pll_sync) begin
          state_d = S_LOCK;
          cause_d = CAUSE_PLL;
        end else if (cnt_q == PERIPH_LAST) begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (!pll_sync) begin
          state_d = S_LOCK;
          cause_d = CAUSE_PLL;
        end else if (cnt_q == MEM_LAST) begin
          state_d = S_CPU;
        end
      end
      S_CPU: begin
        if (!pll_sync) begin
          state_d = S_LOCK;
          cause_d = CAUSE_PLL;
        end else if (cnt_q == CPU_LAST) begin
          state_d = S_RUN;
        end
      end
      // Only the highest-priority event is allowed to record a cause.
      S_RUN: begin
        if (!pll_sync) begin
          state_d = S_LOCK;
          cause_d = CAUSE_PLL;
        end else if (wdt_expire) begin
          state_d = S_SWRST;
          cause_d = CAUSE_WDT;
        end else if (sw_rst_req) begin
          state_d = S_SWRST;
          cause_d = CAUSE_SW;
        end
      end
      S_SWRST:  if (cnt_q == SW_LAST) state_d = S_LOCK;
      default:  state_d = S_HOLD;
    endcase
  end

  // Counter restarts on every state change and saturates instead of wrapping.
  always_comb begin
    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);
  end

  // Output flops are decoded from the next state so each release lands on the
  // same edge as the transition that earns it.
  always_comb begin
    periph_d = state_d inside {S_MEM, S_CPU, S_RUN};
    mem_d    = state_d inside {S_CPU, S_RUN};
    cpu_d    = (state_d == S_RUN);
    done_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      pll_q    <= '0;
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      cause_q  <= CAUSE_POR;
      periph_q <= 1'b0;
      mem_q    <= 1'b0;
      cpu_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pll_q    <= pll_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      periph_q <= periph_d;
      mem_q    <= mem_d;
      cpu_q    <= cpu_d;
      done_q   <= done_d;
    end
  end

  assign rst_periph_n = periph_q;
  assign rst_mem_n    = mem_q;
  assign rst_cpu_n    = cpu_q;
  assign seq_done     = done_q;
  assign rst_cause    = cause_q;

endmodule
